// File: rtl/hoop_pkg.sv
// Shared types and default widths for the hoop arcade game controller.
package hoop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } hoop_state_e;

  localparam int DEF_SCORE_W = 8;
  localparam int DEF_TIME_W  = 8;
  localparam int DEF_ID_W    = 4;

endpackage

// File: rtl/hoop_debounce.sv
// One hoop channel: 2-flop synchroniser, stability debounce, registered
// rising-edge detect producing a single-cycle hit.
module hoop_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic hoop_raw,
  output logic hit
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the
  // accepted level; flip the level once it has disagreed long enough.
  always_comb begin
    sync1_d     = hoop_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    level_dly_d = level_q;
    hit_d       = level_q & ~level_dly_q;
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/hoop_game_ctrl.sv
// Hoop arcade game controller: debounced hoop hits, start-triggered
// countdown, saturating score and a valid/ready hand-off of the result.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | after reset, waiting for start
//   ST_RUN    | countdown running, hits add to score
//   ST_COMMIT | result offered to leaderboard (commit_valid)
//   ST_DONE   | result accepted, waiting for start of next game
module hoop_game_ctrl
  import hoop_pkg::*;
#(
  parameter int N_HOOPS       = 2,
  parameter int GAME_SECS     = 10,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int DB_CYCLES     = 500_000,
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int TIME_W        = DEF_TIME_W,
  parameter int ID_W          = DEF_ID_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [N_HOOPS-1:0] hoop_in,
  input  logic [ID_W-1:0]    user_id,
  output logic [TIME_W-1:0]  time_left,
  output logic [SCORE_W-1:0] score,
  output logic               running,
  output logic               game_over,
  output logic               commit_valid,
  output logic [SCORE_W-1:0] commit_score,
  output logic [ID_W-1:0]    commit_id,
  input  logic               commit_ready
);

  localparam int PS_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int POP_W = $clog2(N_HOOPS + 1);
  localparam int SUM_W = ((SCORE_W > POP_W) ? SCORE_W : POP_W) + 1;
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [SUM_W-1:0] SCORE_MAX = {{(SUM_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  hoop_state_e        state_q, state_d;
  logic [TIME_W-1:0]  time_left_q, time_left_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [PS_W-1:0]    prescaler_q, prescaler_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [N_HOOPS-1:0] hits;
  logic [POP_W-1:0]   hit_count;
  logic [SUM_W-1:0]   score_sum;
  logic               sec_tick;

  for (genvar g = 0; g < N_HOOPS; g++) begin : g_hoop
    hoop_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .hoop_raw(hoop_in[g]),
      .hit     (hits[g])
    );
  end

  // Number of channels that scored this cycle.
  always_comb begin
    hit_count = '0;
    for (int i = 0; i < N_HOOPS; i++) begin
      hit_count = hit_count + POP_W'(hits[i]);
    end
  end

  assign score_sum = SUM_W'(score_q) + SUM_W'(hit_count);
  assign sec_tick  = (prescaler_q == PS_LAST);

  // Game sequencing: start handling, seconds countdown, scoring, hand-off.
  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    prescaler_d = prescaler_q;
    id_d        = id_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          time_left_d = TIME_W'(GAME_SECS);
          score_d     = '0;
          prescaler_d = '0;
          id_d        = user_id;
        end
      end
      ST_RUN: begin
        // Hits on the final tick still count; the score freezes afterwards.
        score_d = (score_sum > SCORE_MAX) ? '1 : score_sum[SCORE_W-1:0];
        if (sec_tick) begin
          prescaler_d = '0;
          time_left_d = time_left_q - TIME_W'(1);
          if (time_left_q == TIME_W'(1)) begin
            state_d = ST_COMMIT;
          end
        end else begin
          prescaler_d = prescaler_q + PS_W'(1);
        end
      end
      ST_COMMIT: begin
        if (commit_ready) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset abandons any game or pending commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      time_left_q <= '0;
      score_q     <= '0;
      prescaler_q <= '0;
      id_q        <= '0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      prescaler_q <= prescaler_d;
      id_q        <= id_d;
    end
  end

  assign time_left    = time_left_q;
  assign score        = score_q;
  assign running      = (state_q == ST_RUN);
  assign game_over    = (state_q == ST_DONE);
  assign commit_valid = (state_q == ST_COMMIT);
  assign commit_score = score_q;
  assign commit_id    = id_q;

endmodule

// File: tb/tb_hoop_game_ctrl.sv
// Bench for hoop_game_ctrl: two instances (3 s and 15 s games) share all
// inputs; a behavioural model predicts every output each cycle.
module tb_hoop_game_ctrl;

  localparam int TPS = 4;
  localparam int DB  = 3;
  localparam int NH  = 2;
  localparam int SW  = 4;
  localparam int TW  = 8;
  localparam int IW  = 4;
  localparam int GS0 = 3;
  localparam int GS1 = 15;
  localparam int SMAX = 15;
  localparam int M_IDLE = 0, M_RUN = 1, M_COMMIT = 2, M_DONE = 3;

  logic          clock;
  logic          reset;
  logic          start;
  logic          commit_ready;
  logic [NH-1:0] hoop_in;
  logic [IW-1:0] user_id;
  logic [TW-1:0] time_left_o    [2];
  logic [SW-1:0] score_o        [2];
  logic          running_o      [2];
  logic          game_over_o    [2];
  logic          commit_valid_o [2];
  logic [SW-1:0] commit_score_o [2];
  logic [IW-1:0] commit_id_o    [2];

  int checks = 0;
  int errors = 0;

  hoop_game_ctrl #(
    .N_HOOPS(NH), .GAME_SECS(GS0), .TICKS_PER_SEC(TPS), .DB_CYCLES(DB),
    .SCORE_W(SW), .TIME_W(TW), .ID_W(IW)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .hoop_in(hoop_in), .user_id(user_id),
    .time_left(time_left_o[0]), .score(score_o[0]), .running(running_o[0]),
    .game_over(game_over_o[0]), .commit_valid(commit_valid_o[0]),
    .commit_score(commit_score_o[0]), .commit_id(commit_id_o[0]), .commit_ready(commit_ready)
  );

  hoop_game_ctrl #(
    .N_HOOPS(NH), .GAME_SECS(GS1), .TICKS_PER_SEC(TPS), .DB_CYCLES(DB),
    .SCORE_W(SW), .TIME_W(TW), .ID_W(IW)
  ) u_sat (
    .clock(clock), .reset(reset), .start(start), .hoop_in(hoop_in), .user_id(user_id),
    .time_left(time_left_o[1]), .score(score_o[1]), .running(running_o[1]),
    .game_over(game_over_o[1]), .commit_valid(commit_valid_o[1]),
    .commit_score(commit_score_o[1]), .commit_id(commit_id_o[1]), .commit_ready(commit_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int game_secs(int k);
    return (k == 0) ? GS0 : GS1;
  endfunction

  // ---------------- behavioural model ----------------
  // Raw samples per channel (oldest first); the level flips when the DB
  // samples taken two edges ago and earlier all disagree with it, and a
  // rising flip scores two edges later.
  bit hist [NH][$];
  int due  [NH][$];
  bit m_db [NH];
  int m_mode [2];
  int m_elapsed [2];
  int m_score [2];
  int m_id [2];
  int edge_n = 0;
  bit model_on = 0;

  always @(posedge clock) begin : model
    int  hits_now;
    bit  flip;
    if (!reset) begin
      for (int ch = 0; ch < NH; ch++) begin
        hist[ch].delete();
        repeat (DB + 2) hist[ch].push_back(1'b0);
        due[ch].delete();
        m_db[ch] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = M_IDLE; m_elapsed[k] = 0; m_score[k] = 0; m_id[k] = 0;
      end
      model_on = 1'b1;
    end else begin
      hits_now = 0;
      for (int ch = 0; ch < NH; ch++) begin
        while (due[ch].size() > 0 && due[ch][0] == edge_n) begin
          hits_now++;
          void'(due[ch].pop_front());
        end
        void'(hist[ch].pop_front());
        hist[ch].push_back(hoop_in[ch]);
        flip = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[ch][i] == m_db[ch]) flip = 1'b0;
        if (flip) begin
          m_db[ch] = ~m_db[ch];
          if (m_db[ch]) due[ch].push_back(edge_n + 2);
        end
      end
      for (int k = 0; k < 2; k++) begin
        case (m_mode[k])
          M_IDLE, M_DONE: if (start) begin
            m_mode[k] = M_RUN; m_elapsed[k] = 0; m_score[k] = 0; m_id[k] = int'(user_id);
          end
          M_RUN: begin
            m_score[k] = (m_score[k] + hits_now > SMAX) ? SMAX : m_score[k] + hits_now;
            m_elapsed[k]++;
            if (m_elapsed[k] == game_secs(k) * TPS) m_mode[k] = M_COMMIT;
          end
          default: if (commit_ready) m_mode[k] = M_DONE;
        endcase
      end
    end
    edge_n++;
  end

  // Every cycle, all outputs of both instances against the model.
  always @(negedge clock) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("time_left[%0d]", k), int'(time_left_o[k]),
            (m_mode[k] == M_RUN) ? game_secs(k) - m_elapsed[k] / TPS : 0);
        chk($sformatf("score[%0d]", k), int'(score_o[k]), m_score[k]);
        chk($sformatf("running[%0d]", k), int'(running_o[k]), int'(m_mode[k] == M_RUN));
        chk($sformatf("game_over[%0d]", k), int'(game_over_o[k]), int'(m_mode[k] == M_DONE));
        chk($sformatf("commit_valid[%0d]", k), int'(commit_valid_o[k]), int'(m_mode[k] == M_COMMIT));
        chk($sformatf("commit_score[%0d]", k), int'(commit_score_o[k]), m_score[k]);
        chk($sformatf("commit_id[%0d]", k), int'(commit_id_o[k]), m_id[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(int id);
    start = 1'b1;
    user_id = IW'(id);
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_ready();
    commit_ready = 1'b1;
    cyc(1);
    commit_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
  endtask

  initial begin
    int hold [NH];
    reset = 1'b0; start = 1'b0; commit_ready = 1'b0; hoop_in = '0; user_id = '0;
    cyc(2);
    reset = 1'b1;
    chk("rst_time_left", int'(time_left_o[0]), 0);
    chk("rst_running", int'(running_o[0]), 0);
    chk("rst_commit_id", int'(commit_id_o[0]), 0);
    cyc(2);

    // Game 1: plain countdown, held-off ready.
    pulse_start(5);
    chk("g1_running", int'(running_o[0]), 1);
    chk("g1_tl3", int'(time_left_o[0]), 3);
    cyc(4); chk("g1_tl2", int'(time_left_o[0]), 2);
    cyc(4); chk("g1_tl1", int'(time_left_o[0]), 1);
    cyc(4); chk("g1_tl0", int'(time_left_o[0]), 0);
    chk("g1_valid", int'(commit_valid_o[0]), 1);
    chk("g1_cscore", int'(commit_score_o[0]), 0);
    chk("g1_cid", int'(commit_id_o[0]), 5);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("g1_valid_hold", int'(commit_valid_o[0]), 1);
    end
    pulse_ready();
    chk("g1_done", int'(game_over_o[0]), 1);
    chk("g1_valid_drop", int'(commit_valid_o[0]), 0);

    // Game 2 from DONE: one 6-cycle hit plus a 2-cycle glitch.
    pulse_start(9);
    chk("g2_score0", int'(score_o[0]), 0);
    chk("g2_tl3", int'(time_left_o[0]), 3);
    hoop_in = 2'b11; cyc(2);
    hoop_in = 2'b01; cyc(4);
    hoop_in = 2'b00;
    chk("g2_before_hit", int'(score_o[0]), 0);
    cyc(1); chk("g2_hit", int'(score_o[0]), 1);
    cyc(5);
    chk("g2_valid", int'(commit_valid_o[0]), 1);
    chk("g2_cscore", int'(commit_score_o[0]), 1);
    chk("g2_cid", int'(commit_id_o[0]), 9);
    pulse_ready();

    // Saturation on the 15 s instance: paired rises, 20 hits.
    do_reset();
    chk("rst2_score1", int'(score_o[1]), 0);
    cyc(1);
    pulse_start(3);
    hoop_in = 2'b11; cyc(3);
    hoop_in = 2'b00; cyc(3);
    chk("sat_before", int'(score_o[1]), 0);
    cyc(1); chk("sat_plus2", int'(score_o[1]), 2);
    for (int i = 0; i < 9; i++) begin
      hoop_in = 2'b11; cyc(3);
      hoop_in = 2'b00; cyc(3);
    end
    chk("sat_valid", int'(commit_valid_o[1]), 1);
    chk("sat_cscore", int'(commit_score_o[1]), 15);
    pulse_ready();

    // Hit landing on the final tick is counted.
    pulse_start(1);
    cyc(5); hoop_in = 2'b01;
    cyc(4); hoop_in = 2'b00;
    cyc(3);
    chk("ft_valid", int'(commit_valid_o[0]), 1);
    chk("ft_cscore", int'(commit_score_o[0]), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("ft_cscore_hold", int'(commit_score_o[0]), 1);
    end
    pulse_ready();
    chk("ft_done", int'(game_over_o[0]), 1);

    // Hit one cycle after the final tick is dropped.
    pulse_start(2);
    cyc(6); hoop_in = 2'b01;
    cyc(4); hoop_in = 2'b00;
    cyc(2);
    chk("late_valid", int'(commit_valid_o[0]), 1);
    chk("late_cscore", int'(commit_score_o[0]), 0);
    pulse_ready();

    // start during RUN is ignored.
    pulse_start(4);
    cyc(4); chk("sr_tl2", int'(time_left_o[0]), 2);
    pulse_start(7);
    cyc(3); chk("sr_tl1", int'(time_left_o[0]), 1);
    cyc(4);
    chk("sr_valid", int'(commit_valid_o[0]), 1);
    chk("sr_cid", int'(commit_id_o[0]), 4);

    // Reset mid-COMMIT, then a normal game.
    cyc(1);
    do_reset();
    chk("rc_valid", int'(commit_valid_o[0]), 0);
    chk("rc_cid", int'(commit_id_o[0]), 0);
    chk("rc_game_over", int'(game_over_o[0]), 0);
    pulse_start(6);
    chk("rc_tl3", int'(time_left_o[0]), 3);
    cyc(12);
    chk("rc_valid2", int'(commit_valid_o[0]), 1);
    chk("rc_cid2", int'(commit_id_o[0]), 6);
    pulse_ready();

    // Randomised traffic against the model.
    for (int ch = 0; ch < NH; ch++) hold[ch] = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) != 0);
      start = ($urandom_range(0, 24) == 0);
      user_id = IW'($urandom_range(0, 15));
      commit_ready = ($urandom_range(0, 3) == 0);
      for (int ch = 0; ch < NH; ch++) begin
        if (hold[ch] == 0) begin
          hoop_in[ch] = 1'($urandom_range(0, 1));
          hold[ch] = $urandom_range(1, 6);
        end
        hold[ch]--;
      end
      cyc(1);
    end
    reset = 1'b1; start = 1'b0; commit_ready = 1'b0; hoop_in = '0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
